// File: rtl/oai21_chk_pkg.sv
// Shared types and golden model for the OAI21 exhaustive cell checker.
package oai21_chk_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    // vec packs {A1, A2, B}; returns the expected ZN of a healthy cell
    function automatic logic oai21_golden(input logic [VEC_W-1:0] vec);
        return !((vec[2] | vec[1]) & vec[0]);
    endfunction

endpackage

// File: rtl/oai21_err_tracker.sv
// Saturating mismatch counter plus capture of the first failing vector.
module oai21_err_tracker
    import oai21_chk_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             mismatch,
    input  logic [VEC_W-1:0] vec,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (sample_en && mismatch) begin
            // Hold at all-ones instead of wrapping back to a clean-looking count
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (!fail_valid) begin
                first_fail <= vec;
                fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/oai21_exhaustive_checker.sv
// Sequencer that walks all 8 OAI21 input vectors, waits SETTLE_CYC cycles
// on each, samples ZN and reports pass/fail, error count and first failure.
module oai21_exhaustive_checker
    import oai21_chk_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int LOOPS      = 1,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    output logic             A1,
    output logic             A2,
    output logic             B,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [VEC_W-1:0] FIRST_FAIL,
    output logic             FAIL_VALID
);

    localparam int TMR_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VEC - 1);
    localparam logic [TMR_W-1:0]  LAST_TMR  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);

    state_t              state;
    logic [VEC_W-1:0]    vec;
    logic [LOOP_W-1:0]   loop_cnt;
    logic [TMR_W-1:0]    timer;
    logic                busy;
    logic                done;
    logic                pass;

    logic accept;
    logic sample_en;
    logic mismatch;

    assign accept    = (state == IDLE) && START && !ABORT;
    // An abort landing on the sample cycle discards that sample
    assign sample_en = (state == SAMPLE) && !ABORT;
    assign mismatch  = (ZN != oai21_golden(vec));

    assign {A1, A2, B} = vec;
    assign BUSY        = busy;
    assign DONE        = done;
    assign PASS        = pass;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            vec      <= '0;
            loop_cnt <= '0;
            timer    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && ABORT) begin
                state    <= IDLE;
                vec      <= '0;
                loop_cnt <= '0;
                timer    <= '0;
                busy     <= 1'b0;
                pass     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            vec      <= '0;
                            loop_cnt <= '0;
                            timer    <= '0;
                            pass     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (timer == LAST_TMR) begin
                            state <= SAMPLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (vec == LAST_VEC && loop_cnt == LAST_LOOP) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            vec   <= vec + 1'b1;
                            timer <= '0;
                            if (vec == LAST_VEC) begin
                                loop_cnt <= loop_cnt + 1'b1;
                            end
                            state <= SETTLE;
                        end
                    end
                    FINISH: begin
                        // ERR_CNT already includes the final sample here
                        pass  <= (ERR_CNT == '0);
                        vec   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    oai21_err_tracker #(
        .ERR_W(ERR_W)
    ) u_err_tracker (
        .clk        (CLK),
        .rst        (RST),
        .clear      (accept),
        .sample_en  (sample_en),
        .mismatch   (mismatch),
        .vec        (vec),
        .err_cnt    (ERR_CNT),
        .first_fail (FIRST_FAIL),
        .fail_valid (FAIL_VALID)
    );

endmodule

// File: tb/tb_oai21_exhaustive_checker.sv
// Bench for oai21_exhaustive_checker: four instances with different parameters,
// each driven by its own behavioural cell model (clean/faulty, stuck, delayed).
module tb_oai21_exhaustive_checker;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] start_v = '0;
    logic [3:0] abort_v = '0;

    logic       a1_0, a2_0, b_0, zn0, busy0, done0, pass0, fv0;
    logic [7:0] err0;
    logic [2:0] ff0;
    logic       a1_1, a2_1, b_1, zn1, busy1, done1, pass1, fv1;
    logic [1:0] err1;
    logic [2:0] ff1;
    logic       a1_2, a2_2, b_2, zn2, busy2, done2, pass2, fv2;
    logic [7:0] err2;
    logic [2:0] ff2;
    logic       a1_3, a2_3, b_3, zn3, busy3, done3, pass3, fv3;
    logic [7:0] err3;
    logic [2:0] ff3;

    logic [7:0]  mask0 = '0;
    logic [14:0] hist2 = '0;
    logic [14:0] hist3 = '0;

    int sel = 0;
    int checks = 0;
    int errors = 0;

    logic [2:0] obs_vec;
    logic       obs_busy, obs_done, obs_pass, obs_fv;
    logic [7:0] obs_err;
    logic [2:0] obs_ff;

    always #5 CLK = ~CLK;

    // Truth table of a healthy OAI21 for vec {A1,A2,B} = 0..7: 1,1,1,0,1,0,1,0
    function automatic logic ref_zn(input logic [2:0] v);
        logic [7:0] t;
        t = 8'h57;
        return t[v];
    endfunction

    // dut0: healthy cell with a per-vector fault mask; dut1: stuck at 0;
    // dut2/dut3: healthy cell whose output lags its inputs by 4 cycles
    assign zn0 = ref_zn({a1_0, a2_0, b_0}) ^ mask0[{a1_0, a2_0, b_0}];
    assign zn1 = 1'b0;
    assign zn2 = ref_zn(hist2[14:12]);
    assign zn3 = ref_zn(hist3[14:12]);

    always @(negedge CLK) begin
        hist2 <= {hist2[11:0], a1_2, a2_2, b_2};
        hist3 <= {hist3[11:0], a1_3, a2_3, b_3};
    end

    oai21_exhaustive_checker dut0 (
        .CLK(CLK), .RST(RST), .START(start_v[0]), .ABORT(abort_v[0]),
        .A1(a1_0), .A2(a2_0), .B(b_0), .ZN(zn0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_CNT(err0), .FIRST_FAIL(ff0), .FAIL_VALID(fv0)
    );

    oai21_exhaustive_checker #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(2)) dut1 (
        .CLK(CLK), .RST(RST), .START(start_v[1]), .ABORT(abort_v[1]),
        .A1(a1_1), .A2(a2_1), .B(b_1), .ZN(zn1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FIRST_FAIL(ff1), .FAIL_VALID(fv1)
    );

    oai21_exhaustive_checker #(.SETTLE_CYC(4)) dut2 (
        .CLK(CLK), .RST(RST), .START(start_v[2]), .ABORT(abort_v[2]),
        .A1(a1_2), .A2(a2_2), .B(b_2), .ZN(zn2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FIRST_FAIL(ff2), .FAIL_VALID(fv2)
    );

    oai21_exhaustive_checker #(.SETTLE_CYC(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(start_v[3]), .ABORT(abort_v[3]),
        .A1(a1_3), .A2(a2_3), .B(b_3), .ZN(zn3),
        .BUSY(busy3), .DONE(done3), .PASS(pass3),
        .ERR_CNT(err3), .FIRST_FAIL(ff3), .FAIL_VALID(fv3)
    );

    always_comb begin
        obs_vec  = '0;
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_pass = 1'b0;
        obs_fv   = 1'b0;
        obs_err  = '0;
        obs_ff   = '0;
        case (sel)
            0: begin
                obs_vec = {a1_0, a2_0, b_0}; obs_busy = busy0; obs_done = done0;
                obs_pass = pass0; obs_fv = fv0; obs_err = err0; obs_ff = ff0;
            end
            1: begin
                obs_vec = {a1_1, a2_1, b_1}; obs_busy = busy1; obs_done = done1;
                obs_pass = pass1; obs_fv = fv1; obs_err = {6'b0, err1}; obs_ff = ff1;
            end
            2: begin
                obs_vec = {a1_2, a2_2, b_2}; obs_busy = busy2; obs_done = done2;
                obs_pass = pass2; obs_fv = fv2; obs_err = err2; obs_ff = ff2;
            end
            3: begin
                obs_vec = {a1_3, a2_3, b_3}; obs_busy = busy3; obs_done = done3;
                obs_pass = pass3; obs_fv = fv3; obs_err = err3; obs_ff = ff3;
            end
            default: begin
                obs_vec = '0;
            end
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, int'(obs_busy), 0);
        chk({tag, "_done"}, int'(obs_done), 0);
        chk({tag, "_pass"}, int'(obs_pass), 0);
        chk({tag, "_err"},  int'(obs_err), 0);
        chk({tag, "_fv"},   int'(obs_fv), 0);
        chk({tag, "_ff"},   int'(obs_ff), 0);
        chk({tag, "_vec"},  int'(obs_vec), 0);
    endtask

    // Pulses START, follows the vector walk cycle by cycle and waits (bounded)
    // for DONE. Cycle 1 is the cycle after the edge that accepts START.
    task automatic run_check(input string tag, input int idx, input int s,
                             input int l, input int glitch);
        int t_done;
        int limit;
        int done_at;
        int trace_bad;
        t_done    = 1 + l * 8 * (s + 1);
        limit     = t_done + 5;
        done_at   = -1;
        trace_bad = 0;
        sel       = idx;
        start_v[idx] = 1'b1;
        @(negedge CLK);
        start_v[idx] = 1'b0;
        for (int c = 1; c <= limit && done_at < 0; c++) begin
            if (obs_done) begin
                done_at = c;
            end else if (c < t_done) begin
                if (obs_vec != 3'(((c - 1) / (s + 1)) % 8)) trace_bad++;
                if (!obs_busy) trace_bad++;
            end
            start_v[idx] = (c == glitch);
            @(negedge CLK);
        end
        start_v[idx] = 1'b0;
        chk({tag, "_done_cycle"}, done_at, t_done);
        chk({tag, "_trace_errs"}, trace_bad, 0);
    endtask

    task automatic check_result(input string tag, input int pass_e, input int err_e,
                                input int fv_e, input int ff_e);
        chk({tag, "_pass"}, int'(obs_pass), pass_e);
        chk({tag, "_err"},  int'(obs_err), err_e);
        chk({tag, "_fv"},   int'(obs_fv), fv_e);
        chk({tag, "_ff"},   int'(obs_ff), ff_e);
        chk({tag, "_busy"}, int'(obs_busy), 0);
        chk({tag, "_done_low"}, int'(obs_done), 0);
    endtask

    // One default-parameter run on dut0; the mask marks which vectors the cell gets wrong
    task automatic mask_run(input string tag, input logic [7:0] m, input int glitch);
        int nerr;
        int first;
        nerr  = $countones(m);
        first = 0;
        for (int v = 7; v >= 0; v--) begin
            if (m[v]) first = v;
        end
        mask0 = m;
        run_check(tag, 0, 2, 1, glitch);
        check_result(tag, (m == 0) ? 1 : 0, (nerr > 255) ? 255 : nerr,
                     (m != 0) ? 1 : 0, first);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] tab;
        int raw;
        int nerr;
        int first;
        int done_seen;

        tab = 8'h57;
        repeat (2) @(negedge CLK);
        sel = 0;
        check_reset("rst_dut0");
        sel = 1;
        check_reset("rst_dut1");
        RST = 1'b0;
        @(negedge CLK);

        // Healthy cell, default parameters
        mask_run("clean", 8'h00, 0);

        // ZN stuck at 1: every vector whose golden value is 0 mismatches
        m = ~tab;
        mask_run("stuck1", m, 0);
        sel = 0;
        chk("stuck1_err_literal", int'(obs_err), 3);
        chk("stuck1_ff_literal", int'(obs_ff), 3);

        // ZN stuck at 0 over 3 loops with a 2-bit counter
        raw = 3 * $countones(tab);
        run_check("sat", 1, 2, 3, 0);
        check_result("sat", 0, (raw > 3) ? 3 : raw, 1, 0);

        // Slow cell: enough settle time passes, too little fails
        run_check("dly4", 2, 4, 1, 0);
        check_result("dly4", 1, 0, 0, 0);
        nerr  = 0;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            // With 3 settle cycles the sample still sees the previous vector's output
            if (tab[k] != tab[(k == 0) ? 0 : k - 1]) begin
                nerr++;
                if (first < 0) first = k;
            end
        end
        run_check("dly3", 3, 3, 1, 0);
        check_result("dly3", 0, nerr, 1, (first < 0) ? 0 : first);

        // ABORT in cycle 10 after an error on vec 1
        sel   = 0;
        mask0 = 8'h02;
        start_v[0] = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        repeat (9) @(negedge CLK);
        abort_v[0] = 1'b1;
        @(negedge CLK);
        abort_v[0] = 1'b0;
        chk("abort_busy", int'(obs_busy), 0);
        chk("abort_vec", int'(obs_vec), 0);
        chk("abort_pass", int'(obs_pass), 0);
        chk("abort_err_kept", int'(obs_err), 1);
        chk("abort_fv_kept", int'(obs_fv), 1);
        chk("abort_ff_kept", int'(obs_ff), 1);
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (obs_done) done_seen++;
            @(negedge CLK);
        end
        chk("abort_no_done", done_seen, 0);

        // START together with ABORT in IDLE is refused
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("start_abort_busy", int'(obs_busy), 0);
        chk("start_abort_err_kept", int'(obs_err), 1);
        @(negedge CLK);
        chk("start_abort_busy_later", int'(obs_busy), 0);

        // Extra START while busy leaves the run untouched
        mask_run("glitch", 8'h00, 5);

        // RST in cycle 7 of a run that already has an error on vec 0
        sel   = 0;
        mask0 = 8'h01;
        start_v[0] = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        repeat (6) @(negedge CLK);
        chk("pre_rst_err", int'(obs_err), 1);
        chk("pre_rst_busy", int'(obs_busy), 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset("rst_mid");
        @(negedge CLK);
        chk("rst_mid_stays_idle", int'(obs_busy), 0);

        // Random fault masks against the table-driven model
        for (int i = 0; i < 6; i++) begin
            m = 8'($urandom());
            mask_run("rand", m, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
